ram_masked_init: RTL
====================

RAM_MASKED_INIT -- requirements
Module: ram_masked_init

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: word width in bits; must be a multiple of LANE_WIDTH.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter LANE_WIDTH, default 8: write-mask granularity; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1: legal values 1 or 2 cycles, request to data.
REQ-005 SHALL have parameter WRITE_FIRST, default 1: same-cycle read/write collision policy (1 = new data, 0 = old data).
REQ-006 SHALL have parameter INIT_ON_RESET, default 1: 1 = start a clear sweep automatically after reset release.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-008 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port s_init_req, input, 1: start a clear sweep; honoured only in IDLE.
REQ-010 SHALL have port s_busy, output, 1: high while in INIT.
REQ-011 SHALL have port s_init_done, output, 1: one-cycle pulse on the last sweep write.
REQ-012 SHALL have port s_read_req, input, 1: read request.
REQ-013 SHALL have port s_read_addr, input, ADDR_WIDTH: read address.
REQ-014 SHALL have port s_read_data, output, DATA_WIDTH: read data.
REQ-015 SHALL have port s_read_valid, output, 1: s_read_data is valid this cycle.
REQ-016 SHALL have port s_write_req, input, 1: write request.
REQ-017 SHALL have port s_write_addr, input, ADDR_WIDTH: write address.
REQ-018 SHALL have port s_write_data, input, DATA_WIDTH: write data.
REQ-019 SHALL have port s_write_mask, input, NUM_LANES: per-lane write enable; bit i covers data bits [i*LANE_WIDTH +: LANE_WIDTH].

Function
REQ-020 SHALL implement FSM states IDLE and INIT: IDLE->INIT on s_init_req; INIT->IDLE on the cycle after the write to address 2**ADDR_WIDTH-1.
REQ-021 SHALL, in INIT, write all-zero words at addresses 0,1,2,... at one per cycle, so a sweep takes exactly 2**ADDR_WIDTH cycles.
REQ-022 SHALL, in INIT, drop s_read_req and s_write_req with no memory change and no s_read_valid; s_init_req during INIT SHALL be ignored.
REQ-023 SHALL, in IDLE, on s_write_req update only the lanes whose s_write_mask bit is 1; a mask of all zeros SHALL leave memory unchanged.
REQ-024 SHALL, in IDLE, accept s_read_req every cycle (no back-pressure) and assert s_read_valid exactly READ_LATENCY cycles later, for one cycle per accepted request.
REQ-025 SHALL hold s_read_data stable between valid pulses; back-to-back reads SHALL produce back-to-back valid pulses.
REQ-026 SHALL, on a same-cycle read and write to the same address with WRITE_FIRST=1, return old data merged with new data on the masked lanes; with WRITE_FIRST=0, return the pre-write word.
REQ-027 SHALL keep read and write with different addresses in the same cycle fully independent.
REQ-028 SHALL pulse s_init_done in the same cycle as the sweep write to the last address, with s_busy still high.

Reset
REQ-029 SHALL, on reset assertion, immediately force s_read_data=0, s_read_valid=0, s_busy=0, s_init_done=0, the sweep counter to 0 and the FSM to IDLE, discarding in-flight reads.
REQ-030 SHALL NOT clear memory contents on reset; a sweep interrupted by reset SHALL leave already-swept words zero and the rest unchanged.
REQ-031 SHALL, when INIT_ON_RESET=1, enter INIT on the first clock edge after reset deassertion; when INIT_ON_RESET=0, remain in IDLE.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, INIT) and a mask-to-bit-enable expansion function in shared package ram_pkg.
REQ-033 SHALL build storage from NUM_LANES instances of sub-module ram_lane, a LANE_WIDTH-wide simple dual-port memory with per-lane write enable.
REQ-034 SHALL implement the read-latency pipeline and collision merge in the top module, outside ram_lane.

Verification
REQ-035 SHALL test auto-init: INIT_ON_RESET=1, ADDR_WIDTH=4 -> s_busy high for 16 cycles, s_init_done on cycle 16, then reads of all addresses return 0.
REQ-036 SHALL test masked write: write 0x1122334455667788 to addr 5 with mask 0xFF, then 0xAAAAAAAAAAAAAAAA with mask 0x0F -> read returns 0x11223344AAAAAAAA.
REQ-037 SHALL test latency: READ_LATENCY=2, reads at cycles t, t+1 and t+2 -> valid at t+2, t+3 and t+4 with the matching data.
REQ-038 SHALL test collision: addr 3 holds 0x0, read and write 0xFFFF (mask 0x03) to addr 3 in the same cycle -> returns 0xFFFF with WRITE_FIRST=1 and 0x0 with WRITE_FIRST=0.
REQ-039 SHALL test requests during INIT: write 0x55 to addr 2 mid-sweep -> addr 2 reads 0 after the sweep, and no s_read_valid during INIT.
REQ-040 SHALL test reset mid-sweep: preload all words to 0xFF, reset at sweep address 7, INIT_ON_RESET=0 -> addrs 0-6 read 0, addrs 7-15 read 0xFF, s_busy low.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared FSM states and write-mask expansion for the masked, self-clearing RAM.
// Combinational helpers only: no latency and no backpressure.
package ram_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_t;

  // Widest word the mask expansion can serve; callers cast the result down.
  localparam int MAX_BITS = 256;

  function automatic logic [MAX_BITS-1:0] mask_to_bits(
    input logic [MAX_BITS-1:0] mask,
    input int unsigned         lane_width,
    input int unsigned         num_lanes
  );
    logic [MAX_BITS-1:0] lane_ones;
    logic [MAX_BITS-1:0] m;
    logic [MAX_BITS-1:0] bits;
    lane_ones = '1;
    lane_ones = ~(lane_ones << lane_width);
    m         = mask;
    bits      = '0;
    for (int unsigned l = 0; l < MAX_BITS; l++) begin
      if (l < num_lanes && m[0]) bits = bits | (lane_ones << (l * lane_width));
      m = m >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/ram_lane.sv
// One byte-lane slice: simple dual-port memory, registered read (1 cycle, old data on collision).
// Always ready; the read register holds its value until the next read enable.
module ram_lane #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage is deliberately not reset: contents must survive a reset.
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_masked_init.sv
// Lane-masked dual-port RAM with a hardware clear sweep; read data READ_LATENCY (1|2) cycles after request.
// No backpressure in IDLE; during the sweep all read/write requests are dropped.
module ram_masked_init
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 12,
  parameter int LANE_WIDTH    = 8,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_FIRST   = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             s_init_req,
  output logic                             s_busy,
  output logic                             s_init_done,
  input  logic                             s_read_req,
  input  logic [ADDR_WIDTH-1:0]            s_read_addr,
  output logic [DATA_WIDTH-1:0]            s_read_data,
  output logic                             s_read_valid,
  input  logic                             s_write_req,
  input  logic [ADDR_WIDTH-1:0]            s_write_addr,
  input  logic [DATA_WIDTH-1:0]            s_write_data,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] s_write_mask
);

  localparam int NUM_LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'((1 << ADDR_WIDTH) - 1);
  localparam logic [ADDR_WIDTH-1:0] PEN_ADDR  = ADDR_WIDTH'((1 << ADDR_WIDTH) - 2);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  logic                    auto_init;
  logic                    idle;
  logic                    rd_fire;
  logic [DATA_WIDTH-1:0]   wr_bits;
  logic [NUM_LANES-1:0]    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   lane_q;
  logic                    rd_vld1;
  logic                    col_hit;
  logic [DATA_WIDTH-1:0]   col_bits;
  logic [DATA_WIDTH-1:0]   col_data;
  logic [DATA_WIDTH-1:0]   word1;

  // auto_init carries the post-reset sweep request into the first clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sweep_addr  <= '0;
      s_busy      <= 1'b0;
      s_init_done <= 1'b0;
      auto_init   <= (INIT_ON_RESET != 0);
    end else begin
      case (state)
        IDLE: begin
          s_init_done <= 1'b0;
          auto_init   <= 1'b0;
          if (s_init_req || auto_init) begin
            state      <= INIT;
            s_busy     <= 1'b1;
            sweep_addr <= '0;
          end
        end
        INIT: begin
          sweep_addr  <= sweep_addr + ADDR_WIDTH'(1);
          s_init_done <= (sweep_addr == PEN_ADDR);
          if (sweep_addr == LAST_ADDR) begin
            state  <= IDLE;
            s_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign idle    = (state == IDLE);
  assign rd_fire = idle && s_read_req;
  assign wr_bits = DATA_WIDTH'(mask_to_bits(MAX_BITS'(s_write_mask), LANE_WIDTH, NUM_LANES));

  always_comb begin
    mem_we    = idle ? (s_write_mask & {NUM_LANES{s_write_req}}) : '1;
    mem_waddr = idle ? s_write_addr : sweep_addr;
    mem_wdata = idle ? s_write_data : '0;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    ram_lane #(
      .WIDTH      (LANE_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we[l]),
      .waddr (mem_waddr),
      .wdata (mem_wdata[l*LANE_WIDTH +: LANE_WIDTH]),
      .re    (rd_fire),
      .raddr (s_read_addr),
      .rdata (lane_q[l*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  // The lanes return pre-write data; the write side of a colliding pair is kept to patch it in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld1  <= 1'b0;
      col_hit  <= 1'b0;
      col_bits <= '0;
      col_data <= '0;
    end else begin
      rd_vld1 <= rd_fire;
      if (rd_fire) begin
        col_hit  <= (WRITE_FIRST != 0) && s_write_req && (s_write_addr == s_read_addr);
        col_bits <= wr_bits;
        col_data <= s_write_data;
      end
    end
  end

  assign word1 = col_hit ? ((lane_q & ~col_bits) | (col_data & col_bits)) : lane_q;

  if (READ_LATENCY == 2) begin : g_rl2
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s_read_valid <= 1'b0;
        s_read_data  <= '0;
      end else begin
        s_read_valid <= rd_vld1;
        if (rd_vld1) s_read_data <= word1;
      end
    end
  end else begin : g_rl1
    assign s_read_valid = rd_vld1;
    assign s_read_data  = word1;
  end

endmodule
